// File: rtl/gf_mixcol_seq_if.sv
// Start/busy/done handshake and state buses for the iterative MixColumns engine.
interface gf_mixcol_seq_if;
  logic         start;
  logic         inv;
  logic [127:0] state_in;
  logic         busy;
  logic         done;
  logic [127:0] state_out;

  modport master (
    output start, inv, state_in,
    input  busy, done, state_out
  );

  modport slave (
    input  start, inv, state_in,
    output busy, done, state_out
  );
endinterface

// File: rtl/gf_mixcol_seq.sv
// Iterative AES MixColumns / InvMixColumns: one GF(2^8) product per clock,
// 64 clocks per 128-bit state, shared single multiplier.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; busy=0
// RUN   | cnt walks c,r,k; one product accumulated per clock
// DONE  | done pulse; state_out already valid; may accept the next start
module gf_mixcol_seq (
  input  logic            clk,
  input  logic            rst_n,
  gf_mixcol_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       st;
  logic [5:0]   cnt;
  logic [7:0]   acc;
  logic [127:0] res;
  logic [127:0] s_q;
  logic         inv_q;
  logic         busy_q;
  logic         done_q;
  logic [127:0] out_q;

  logic [1:0]   c_i, r_i, k_i, j_i;
  logic [7:0]   coef;
  logic [7:0]   opb;
  logic [7:0]   prod;
  logic [7:0]   acc_nxt;

  // Carry-less multiply reduced by x^8+x^4+x^3+x+1
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = b;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  assign c_i = cnt[5:4];
  assign r_i = cnt[3:2];
  assign k_i = cnt[1:0];
  assign j_i = k_i - r_i;

  // Circulant row coefficient for (k-r) mod 4
  always_comb begin
    coef = 8'h01;
    case ({inv_q, j_i})
      3'b000:  coef = 8'h02;
      3'b001:  coef = 8'h03;
      3'b010:  coef = 8'h01;
      3'b011:  coef = 8'h01;
      3'b100:  coef = 8'h0e;
      3'b101:  coef = 8'h0b;
      3'b110:  coef = 8'h0d;
      3'b111:  coef = 8'h09;
      default: coef = 8'h01;
    endcase
  end

  // Byte k+4c sits at bit offset 8*(15-(k+4c)); 15-x is ~x for 4 bits
  assign opb     = s_q[{~c_i, ~k_i, 3'b000} +: 8];
  assign prod    = gf_mul(coef, opb);
  assign acc_nxt = ((k_i == 2'd0) ? 8'h00 : acc) ^ prod;

  // Sequencer, accumulator and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st     <= IDLE;
      cnt    <= 6'd0;
      acc    <= 8'h00;
      res    <= 128'h0;
      s_q    <= 128'h0;
      inv_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      out_q  <= 128'h0;
    end else begin
      case (st)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            s_q    <= bus.state_in;
            inv_q  <= bus.inv;
            cnt    <= 6'd0;
            acc    <= 8'h00;
            busy_q <= 1'b1;
            st     <= RUN;
          end else begin
            busy_q <= 1'b0;
            st     <= IDLE;
          end
        end
        RUN: begin
          cnt <= cnt + 6'd1;
          if (k_i == 2'd3) begin
            res[{~c_i, ~r_i, 3'b000} +: 8] <= acc_nxt;
            acc <= 8'h00;
          end else begin
            acc <= acc_nxt;
          end
          // Last byte (r=3,c=3) is the low byte; merge it so state_out updates whole
          if (cnt == 6'd63) begin
            out_q  <= {res[127:8], acc_nxt};
            done_q <= 1'b1;
            st     <= DONE;
          end
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          st     <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.state_out = out_q;

endmodule

// File: tb/tb_gf_mixcol_seq.sv
// Self-checking bench for gf_mixcol_seq: directed vectors, lockout, mid-run
// reset and random forward/inverse round trips against a matrix model.
module tb_gf_mixcol_seq;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  gf_mixcol_seq_if bus();

  gf_mixcol_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int fwd_m[4] = '{2, 3, 1, 1};
  int inv_m[4] = '{14, 11, 13, 9};

  // Polynomial product, then long division by 0x11B
  function automatic int gmul_ref(int a, int b);
    int p;
    p = 0;
    for (int i = 0; i < 8; i++)
      if (((a >> i) & 1) == 1) p = p ^ (b << i);
    for (int i = 14; i >= 8; i--)
      if (((p >> i) & 1) == 1) p = p ^ (32'h11b << (i - 8));
    return p & 255;
  endfunction

  // out[r][c] = sum_k M[(k-r) mod 4] * s[k][c], bytes column-major from MSB
  function automatic logic [127:0] mix_ref(logic [127:0] s, bit iv);
    int b[16];
    int o;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = int'(s[127 - 8*i -: 8]);
    r = '0;
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) begin
        o = 0;
        for (int k = 0; k < 4; k++)
          o = o ^ gmul_ref(iv ? inv_m[(k - rr + 4) % 4] : fwd_m[(k - rr + 4) % 4], b[k + 4*c]);
        r[127 - 8*(rr + 4*c) -: 8] = o[7:0];
      end
    return r;
  endfunction

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // One transform with a one-cycle start; checks latency, busy span, hold and return to idle
  task automatic xform(string tag, logic [127:0] din, bit iv, output logic [127:0] dout);
    int cyc;
    int bcnt;
    logic [127:0] hold;
    bit stable;
    @(negedge clk);
    bus.start    = 1'b1;
    bus.inv      = iv;
    bus.state_in = din;
    hold = bus.state_out;
    @(posedge clk);
    @(negedge clk);
    bus.start    = 1'b0;
    bus.state_in = {$urandom, $urandom, $urandom, $urandom};
    bus.inv      = ~iv;
    cyc = 0;
    bcnt = bus.busy ? 1 : 0;
    stable = 1'b1;
    while (!bus.done && cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (bus.busy) bcnt++;
      if (!bus.done && bus.state_out !== hold) stable = 1'b0;
    end
    dout = bus.state_out;
    chk({tag, "_latency"}, 128'(cyc), 128'd64);
    chk({tag, "_busy_cycles"}, 128'(bcnt), 128'd65);
    chk({tag, "_out_stable"}, 128'(stable), 128'd1);
    @(negedge clk);
    chk({tag, "_idle_busy"}, 128'(bus.busy), 128'd0);
    chk({tag, "_idle_done"}, 128'(bus.done), 128'd0);
    chk({tag, "_idle_hold"}, bus.state_out, dout);
  endtask

  logic [127:0] a_v, b_v, y, z, r1, r2;
  int cyc, nd, c1, c2, bsy65;

  initial begin
    tests = 0;
    fails = 0;

    // Reset held with start high
    rst_n        = 1'b0;
    bus.start    = 1'b1;
    bus.inv      = 1'b0;
    bus.state_in = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    chk("rst_done", 128'(bus.done), 128'd0);
    chk("rst_out", bus.state_out, 128'h0);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    chk("rst_release_busy", 128'(bus.busy), 128'd0);

    // Directed vectors
    xform("fwd_vec", 128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, y);
    chk("fwd_vec_out", y, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);
    xform("inv_vec", 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, 1'b1, y);
    chk("inv_vec_out", y, 128'hdb135345_f20a225c_01010101_c6c6c6c6);
    a_v = 128'hd4d4d4d5_c6c6c6c6_01010101_d4d4d4d5;
    xform("d4_fwd", a_v, 1'b0, y);
    chk("d4_fwd_out", y, 128'hd5d5d7d6_c6c6c6c6_01010101_d5d5d7d6);
    chk("d4_fwd_model", y, mix_ref(a_v, 1'b0));
    xform("d4_inv", y, 1'b1, z);
    chk("d4_roundtrip", z, a_v);

    // Busy lockout: second request held from cycle 10 through DONE
    a_v = {$urandom, $urandom, $urandom, $urandom};
    b_v = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    bus.start    = 1'b1;
    bus.inv      = 1'b0;
    bus.state_in = a_v;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0; nd = 0; c1 = -1; c2 = -1; bsy65 = -1; r1 = '0; r2 = '0;
    while (cyc < 200) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (cyc == 10) begin
        bus.start    = 1'b1;
        bus.inv      = 1'b1;
        bus.state_in = b_v;
      end
      if (cyc == 65) begin
        bsy65     = bus.busy ? 1 : 0;
        bus.start = 1'b0;
      end
      if (bus.done) begin
        nd++;
        if (nd == 1) begin c1 = cyc; r1 = bus.state_out; end
        else if (nd == 2) begin c2 = cyc; r2 = bus.state_out; end
      end
    end
    chk("lock_first_cyc", 128'(c1), 128'd64);
    chk("lock_first_out", r1, mix_ref(a_v, 1'b0));
    chk("lock_busy_e65", 128'(bsy65), 128'd1);
    chk("lock_second_cyc", 128'(c2), 128'd129);
    chk("lock_second_out", r2, mix_ref(b_v, 1'b1));
    chk("lock_done_count", 128'(nd), 128'd2);
    chk("lock_idle_busy", 128'(bus.busy), 128'd0);

    // Reset at cycle 30 of RUN
    a_v = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    bus.start    = 1'b1;
    bus.inv      = 1'b0;
    bus.state_in = a_v;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_busy", 128'(bus.busy), 128'd0);
    chk("midrst_out", bus.state_out, 128'h0);
    chk("midrst_done", 128'(bus.done), 128'd0);
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) nd++;
    end
    chk("midrst_no_done", 128'(nd), 128'd0);
    xform("midrst_fresh", a_v, 1'b0, y);
    chk("midrst_fresh_out", y, mix_ref(a_v, 1'b0));

    // Random forward/inverse round trips
    for (int n = 0; n < 200; n++) begin
      a_v = {$urandom, $urandom, $urandom, $urandom};
      xform("rnd_fwd", a_v, 1'b0, y);
      chk("rnd_fwd_out", y, mix_ref(a_v, 1'b0));
      xform("rnd_inv", y, 1'b1, z);
      chk("rnd_roundtrip", z, a_v);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
